// File: rtl/note_player_pkg.sv
// note_player_pkg
// Shared definitions for the note player: one-hot FSM state encodings,
// the rest-note code, default datapath widths and the audio sample rate
// that the note step table was derived from.
package note_player_pkg;

  // One-hot state encoding for the note player FSM.
  typedef enum logic [2:0] {
    NP_IDLE    = 3'b001,
    NP_PLAYING = 3'b010,
    NP_DONE    = 3'b100
  } np_state_e;

  localparam logic [5:0] NOTE_REST      = 6'd0;
  localparam int         NP_PHASE_W     = 20;
  localparam int         NP_SAMPLE_W    = 16;
  localparam int         NP_SAMPLE_RATE = 48000;
  localparam int         NP_NOTE_W      = 6;

endpackage

// File: rtl/note_step_rom.sv
// note_step_rom
// Combinational note-number to phase-increment table.
//   step = round(440 * 2^((n-49)/12) * 2^20 / 48000), step(0) = 0 (rest).
// The table is scaled for a 20-bit phase accumulator at the 48 kHz sample
// rate; the result is zero-extended or truncated to PHASE_W.
// Ports:
//   note_i  in  6        note number (0 = rest, 49 = A4)
//   step_o  out PHASE_W  phase increment per sample strobe
module note_step_rom
  import note_player_pkg::*;
#(
  parameter int PHASE_W = NP_PHASE_W
) (
  input  logic [NP_NOTE_W-1:0] note_i,
  output logic [PHASE_W-1:0]   step_o
);

  logic [19:0] raw;

  always_comb begin
    raw = 20'd0;
    case (note_i)
      6'd1:  raw = 20'd601;
      6'd2:  raw = 20'd636;
      6'd3:  raw = 20'd674;
      6'd4:  raw = 20'd714;
      6'd5:  raw = 20'd757;
      6'd6:  raw = 20'd802;
      6'd7:  raw = 20'd850;
      6'd8:  raw = 20'd900;
      6'd9:  raw = 20'd954;
      6'd10: raw = 20'd1010;
      6'd11: raw = 20'd1070;
      6'd12: raw = 20'd1134;
      6'd13: raw = 20'd1201;
      6'd14: raw = 20'd1273;
      6'd15: raw = 20'd1349;
      6'd16: raw = 20'd1429;
      6'd17: raw = 20'd1514;
      6'd18: raw = 20'd1604;
      6'd19: raw = 20'd1699;
      6'd20: raw = 20'd1800;
      6'd21: raw = 20'd1907;
      6'd22: raw = 20'd2021;
      6'd23: raw = 20'd2141;
      6'd24: raw = 20'd2268;
      6'd25: raw = 20'd2403;
      6'd26: raw = 20'd2546;
      6'd27: raw = 20'd2697;
      6'd28: raw = 20'd2858;
      6'd29: raw = 20'd3028;
      6'd30: raw = 20'd3208;
      6'd31: raw = 20'd3398;
      6'd32: raw = 20'd3600;
      6'd33: raw = 20'd3815;
      6'd34: raw = 20'd4041;
      6'd35: raw = 20'd4282;
      6'd36: raw = 20'd4536;
      6'd37: raw = 20'd4806;
      6'd38: raw = 20'd5092;
      6'd39: raw = 20'd5395;
      6'd40: raw = 20'd5715;
      6'd41: raw = 20'd6055;
      6'd42: raw = 20'd6415;
      6'd43: raw = 20'd6797;
      6'd44: raw = 20'd7201;
      6'd45: raw = 20'd7629;
      6'd46: raw = 20'd8083;
      6'd47: raw = 20'd8563;
      6'd48: raw = 20'd9072;
      6'd49: raw = 20'd9612;
      6'd50: raw = 20'd10184;
      6'd51: raw = 20'd10789;
      6'd52: raw = 20'd11431;
      6'd53: raw = 20'd12110;
      6'd54: raw = 20'd12830;
      6'd55: raw = 20'd13593;
      6'd56: raw = 20'd14402;
      6'd57: raw = 20'd15258;
      6'd58: raw = 20'd16165;
      6'd59: raw = 20'd17127;
      6'd60: raw = 20'd18145;
      6'd61: raw = 20'd19224;
      6'd62: raw = 20'd20367;
      6'd63: raw = 20'd21578;
      default: raw = 20'd0;
    endcase
  end

  assign step_o = PHASE_W'(raw);

endmodule

// File: rtl/note_player.sv
// note_player
// Times one note at a time against the beat tick and synthesises a signed
// triangle wave at the audio sample strobe. done_with_note requests the
// next note from the song reader (level request in IDLE while enabled,
// one-cycle completion pulse in DONE).
// Ports:
//   clk                   in   1   system clock
//   reset                 in   1   synchronous active-high reset
//   play_enable           in   1   1 = run, 0 = freeze timing/phase, silence
//   note_to_load          in   6   note number (0 = rest)
//   duration_to_load      in   6   note length in beats (0 treated as 1)
//   load_new_note         in   1   capture strobe for note/duration
//   done_with_note        out  1   request / completion to the reader
//   beat                  in   1   one-cycle beat tick
//   generate_next_sample  in   1   one-cycle sample strobe
//   sample_out            out  16  signed sample
//   new_sample_ready      out  1   one-cycle strobe, sample_out valid
// Configuration macro: NOTE_PLAYER_ARTIC_EN -- when defined, the final beat
// of every note is silenced (phase and timing unaffected).
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_W  = NP_PHASE_W,
  parameter int SAMPLE_W = NP_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic [NP_NOTE_W-1:0]       note_to_load,
  input  logic [NP_NOTE_W-1:0]       duration_to_load,
  input  logic                       load_new_note,
  output logic                       done_with_note,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);

  np_state_e                  state_q, state_d;
  logic [NP_NOTE_W-1:0]       note_q, note_d;
  logic [NP_NOTE_W-1:0]       beats_left_q, beats_left_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [PHASE_W-1:0]         phase_next;
  logic [PHASE_W-1:0]         step;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       nsr_q, nsr_d;
  logic                       accept_load;
  logic                       strobe;
  logic                       sounding;

  // Triangle shaper on the top SAMPLE_W phase bits: the MSB folds the ramp,
  // the remaining bits form a 15-bit magnitude u, and {u,0} - 2^(W-1) is the
  // same as inverting the top bit of {u,0}.
  function automatic logic signed [SAMPLE_W-1:0] tri_shape(
    input logic [SAMPLE_W-1:0] ph_top
  );
    logic [SAMPLE_W-2:0] u;
    u = ph_top[SAMPLE_W-1] ? ~ph_top[SAMPLE_W-2:0] : ph_top[SAMPLE_W-2:0];
    return $signed({~u[SAMPLE_W-2], u[SAMPLE_W-3:0], 1'b0});
  endfunction

  note_step_rom #(
    .PHASE_W(PHASE_W)
  ) u_step_rom (
    .note_i (note_q),
    .step_o (step)
  );

  assign strobe     = play_enable && generate_next_sample;
  assign phase_next = phase_q + step;

`ifdef NOTE_PLAYER_ARTIC_EN
  // Final beat is silent so repeated notes are heard as separate notes.
  assign sounding = (state_q == NP_PLAYING) && (note_q != NOTE_REST) &&
                    (beats_left_q != 6'd1);
`else
  assign sounding = (state_q == NP_PLAYING) && (note_q != NOTE_REST);
`endif

  // Next-state: FSM, beat counter and phase accumulator.
  always_comb begin
    state_d      = state_q;
    note_d       = note_q;
    beats_left_d = beats_left_q;
    phase_d      = phase_q;
    accept_load  = 1'b0;

    case (state_q)
      NP_IDLE: begin
        // A load is only honoured while the request is being asserted.
        if (play_enable && load_new_note) accept_load = 1'b1;
      end
      NP_PLAYING: begin
        if (play_enable && beat) begin
          beats_left_d = beats_left_q - 6'd1;
          if (beats_left_q == 6'd1) state_d = NP_DONE;
        end
        if (strobe) phase_d = phase_next;
      end
      NP_DONE: begin
        // DONE always lasts one cycle; a load here chains with no gap.
        if (play_enable && load_new_note) accept_load = 1'b1;
        else                              state_d = NP_IDLE;
      end
      default: state_d = NP_IDLE;
    endcase

    if (accept_load) begin
      note_d       = note_to_load;
      beats_left_d = (duration_to_load == 6'd0) ? 6'd1 : duration_to_load;
      phase_d      = '0;
      state_d      = NP_PLAYING;
    end
  end

  // Next-state: sample output, computed from the freshly advanced phase so
  // the sample appears one cycle after its strobe.
  always_comb begin
    nsr_d    = strobe;
    sample_d = sample_q;
    if (strobe) begin
      sample_d = sounding ? tri_shape(phase_next[PHASE_W-1 -: SAMPLE_W]) : '0;
    end else if (!play_enable || (state_q != NP_PLAYING)) begin
      sample_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NP_IDLE;
      note_q       <= '0;
      beats_left_q <= '0;
      phase_q      <= '0;
      sample_q     <= '0;
      nsr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_q       <= note_d;
      beats_left_q <= beats_left_d;
      phase_q      <= phase_d;
      sample_q     <= sample_d;
      nsr_q        <= nsr_d;
    end
  end

  // Reset masks the IDLE request so the reader sees nothing during reset.
  assign done_with_note   = !reset &&
                            (((state_q == NP_IDLE) && play_enable) ||
                             (state_q == NP_DONE));
  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

  logic              clk = 1'b0;
  logic              reset;
  logic              play_enable;
  logic [5:0]        note_to_load;
  logic [5:0]        duration_to_load;
  logic              load_new_note;
  logic              done_with_note;
  logic              beat;
  logic              generate_next_sample;
  logic signed [15:0] sample_out;
  logic              new_sample_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .done_with_note       (done_with_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note_to_load = n; duration_to_load = d; load_new_note = 1'b1;
    cyc();
    load_new_note = 1'b0;
  endtask

  task automatic strobe();
    generate_next_sample = 1'b1;
    cyc();
    generate_next_sample = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc();
    beat = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; play_enable = 1'b1;
    cyc(); cyc();
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done_with_note); end
    n_cmp++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sample got %0d want 0", sample_out); end
    n_cmp++; if (new_sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_nsr got %0b want 0", new_sample_ready); end
    n_cmp++; if (dut.state_q !== 3'b001) begin n_fail++; $display("FAIL reset_state got %b want 001", dut.state_q); end
    reset = 1'b0;
    #1;
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL idle_request got %0b want 1", done_with_note); end
    load(6'd49, 6'd2);
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL load_done got %0b want 0", done_with_note); end
    n_cmp++; if (dut.state_q !== 3'b010) begin n_fail++; $display("FAIL load_state got %b want 010", dut.state_q); end
    n_cmp++; if (dut.beats_left_q !== 6'd2) begin n_fail++; $display("FAIL load_beats got %0d want 2", dut.beats_left_q); end
  endtask

  task automatic test_samples();
    logic signed [15:0] exp_s [4];
    exp_s[0] = -16'sd31568; exp_s[1] = -16'sd30366;
    exp_s[2] = -16'sd29164; exp_s[3] = -16'sd27962;
    for (int i = 0; i < 4; i++) begin
      strobe();
      n_cmp++; if (new_sample_ready !== 1'b1) begin n_fail++; $display("FAIL nsr_pulse[%0d] got %0b want 1", i, new_sample_ready); end
      n_cmp++; if (sample_out !== exp_s[i]) begin n_fail++; $display("FAIL sample[%0d] got %0d want %0d", i, sample_out, exp_s[i]); end
      cyc();
      n_cmp++; if (new_sample_ready !== 1'b0) begin n_fail++; $display("FAIL nsr_drop[%0d] got %0b want 0", i, new_sample_ready); end
    end
    n_cmp++; if (dut.phase_q !== 20'd38448) begin n_fail++; $display("FAIL phase4 got %0d want 38448", dut.phase_q); end
  endtask

  task automatic test_back_to_back();
    load(6'd37, 6'd5);  // ignored while PLAYING
    n_cmp++; if (dut.beats_left_q !== 6'd2) begin n_fail++; $display("FAIL ignore_load got %0d want 2", dut.beats_left_q); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL beat1_done got %0b want 0", done_with_note); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL beat2_done got %0b want 1", done_with_note); end
    load(6'd37, 6'd1);
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL b2b_done got %0b want 0", done_with_note); end
    n_cmp++; if (dut.state_q !== 3'b010) begin n_fail++; $display("FAIL b2b_state got %b want 010", dut.state_q); end
    n_cmp++; if (dut.phase_q !== 20'd0) begin n_fail++; $display("FAIL b2b_phase got %0d want 0", dut.phase_q); end
    strobe();
    n_cmp++; if (sample_out !== -16'sd32168) begin n_fail++; $display("FAIL note37_sample got %0d want -32168", sample_out); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL note37_done got %0b want 1", done_with_note); end
    play_enable = 1'b0;
    cyc();
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %0b want 0", done_with_note); end
    n_cmp++; if (dut.state_q !== 3'b001) begin n_fail++; $display("FAIL after_done_state got %b want 001", dut.state_q); end
    play_enable = 1'b1;
    #1;
  endtask

  task automatic test_dur0_rest();
    load(6'd49, 6'd0);
    n_cmp++; if (dut.beats_left_q !== 6'd1) begin n_fail++; $display("FAIL dur0_beats got %0d want 1", dut.beats_left_q); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL dur0_done got %0b want 1", done_with_note); end
    cyc();
    load(6'd0, 6'd3);
    strobe();
    n_cmp++; if (new_sample_ready !== 1'b1) begin n_fail++; $display("FAIL rest_nsr got %0b want 1", new_sample_ready); end
    n_cmp++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL rest_sample got %0d want 0", sample_out); end
    for (int i = 0; i < 2; i++) begin
      pulse_beat();
      n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL rest_early_done[%0d] got %0b want 0", i, done_with_note); end
    end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL rest_done got %0b want 1", done_with_note); end
    cyc();
  endtask

  task automatic test_pause();
    load(6'd49, 6'd3);
    strobe();
    n_cmp++; if (sample_out !== -16'sd31568) begin n_fail++; $display("FAIL pause_pre_sample got %0d want -31568", sample_out); end
    pulse_beat();
    play_enable = 1'b0;
    cyc();
    n_cmp++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL pause_silence got %0d want 0", sample_out); end
    for (int i = 0; i < 10; i++) begin
      beat = 1'b1; generate_next_sample = 1'b1;
      cyc();
      n_cmp++; if ({new_sample_ready, done_with_note, sample_out} !== 18'd0) begin n_fail++; $display("FAIL pause_outputs[%0d] got nsr=%0b done=%0b s=%0d want 0/0/0", i, new_sample_ready, done_with_note, sample_out); end
    end
    beat = 1'b0; generate_next_sample = 1'b0;
    n_cmp++; if (dut.phase_q !== 20'd9612) begin n_fail++; $display("FAIL pause_phase got %0d want 9612", dut.phase_q); end
    n_cmp++; if (dut.beats_left_q !== 6'd2) begin n_fail++; $display("FAIL pause_beats got %0d want 2", dut.beats_left_q); end
    play_enable = 1'b1;
    strobe();
    n_cmp++; if (sample_out !== -16'sd30366) begin n_fail++; $display("FAIL resume_sample got %0d want -30366", sample_out); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL resume_beat_done got %0b want 0", done_with_note); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL resume_done got %0b want 1", done_with_note); end
    cyc();
  endtask

  task automatic test_reset_mid_note();
    load(6'd49, 6'd2);
    strobe();
    reset = 1'b1;
    #1;
    n_cmp++; if (done_with_note !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %0b want 0", done_with_note); end
    cyc();
    reset = 1'b0; play_enable = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== 3'b001) begin n_fail++; $display("FAIL midreset_state got %b want 001", dut.state_q); end
    n_cmp++; if ({new_sample_ready, done_with_note, sample_out} !== 18'd0) begin n_fail++; $display("FAIL midreset_outputs got nsr=%0b done=%0b s=%0d want 0/0/0", new_sample_ready, done_with_note, sample_out); end
    n_cmp++; if ({dut.phase_q, dut.beats_left_q} !== 26'd0) begin n_fail++; $display("FAIL midreset_regs got phase=%0d beats=%0d want 0/0", dut.phase_q, dut.beats_left_q); end
    play_enable = 1'b1;
    #1;
  endtask

  task automatic test_artic();
    logic signed [15:0] exp_last;
`ifdef NOTE_PLAYER_ARTIC_EN
    exp_last = 16'sd0;
`else
    exp_last = -16'sd30366;
`endif
    load(6'd49, 6'd2);
    strobe();
    n_cmp++; if (sample_out !== -16'sd31568) begin n_fail++; $display("FAIL artic_first got %0d want -31568", sample_out); end
    pulse_beat();
    strobe();
    n_cmp++; if (sample_out !== exp_last) begin n_fail++; $display("FAIL artic_last got %0d want %0d", sample_out, exp_last); end
    n_cmp++; if (dut.phase_q !== 20'd19224) begin n_fail++; $display("FAIL artic_phase got %0d want 19224", dut.phase_q); end
    pulse_beat();
    n_cmp++; if (done_with_note !== 1'b1) begin n_fail++; $display("FAIL artic_done got %0b want 1", done_with_note); end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; play_enable = 1'b0; note_to_load = '0; duration_to_load = '0;
    load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
    cyc();
    test_reset();
    test_samples();
    test_back_to_back();
    test_dur0_rest();
    test_pause();
    test_reset_mid_note();
    test_artic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
